uart_tx_msg_arbiter: RTL and testbench

//  Shares the single UART transmitter behind axi_to_uart_S00 between N_REQ byte-stream requesters
//  (AXI register path, debug/status sources). Round-robin arbitration at message granularity.
//  A grant is held until the byte flagged last has been transmitted, so messages never interleave.
//  A watchdog revokes a grant whose requester stalls mid-message.

---
 rtl/uart_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_msg_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_msg_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit message arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} arb_state_t;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching ptr+1, ptr+2, ... mod N.
module rr_pick import uart_arb_pkg::*; #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = ptr;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'(rr_next_idx(32'(cand), N));
      if (!found && req[cand]) begin
        found       = 1'b1;
        pick[cand]  = 1'b1;
        pick_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_msg_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmitter between N_REQ
// byte-stream requesters, with a stall watchdog on the granted requester.
module uart_tx_msg_arbiter import uart_arb_pkg::*; #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_dv,
  output logic [BYTE_W-1:0]       tx_byte,
  input  logic                    tx_active,
  input  logic                    tx_done,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    abort_pulse,
  output logic [IW-1:0]           abort_src,
  output logic [CNT_W-1:0]        msg_count
);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] g_idx;
  logic          last_q;
  logic [31:0]   wd_cnt;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic          hs;
  logic          wd_fire;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req      (req_valid),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    if (state == ST_SEND && !tx_active)
      req_ready = grant;
    hs      = (state == ST_SEND) && !tx_active && req_valid[g_idx];
    wd_fire = (TIMEOUT_CYCLES != 0) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
    busy    = (state != ST_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state       <= ST_IDLE;
      ptr         <= IW'(N_REQ - 1);
      g_idx       <= '0;
      grant       <= '0;
      last_q      <= 1'b0;
      wd_cnt      <= '0;
      tx_dv       <= 1'b0;
      tx_byte     <= '0;
      abort_pulse <= 1'b0;
      abort_src   <= '0;
      msg_count   <= '0;
    end else begin
      tx_dv       <= 1'b0;
      abort_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            grant  <= pick;
            g_idx  <= pick_idx;
            wd_cnt <= '0;
            state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A handshake in the final watchdog cycle still wins over the abort.
          if (hs) begin
            tx_byte <= req_data[BYTE_W*g_idx +: BYTE_W];
            last_q  <= req_last[g_idx];
            tx_dv   <= 1'b1;
            wd_cnt  <= '0;
            state   <= ST_WAIT;
          end else if (wd_fire) begin
            abort_pulse <= 1'b1;
            abort_src   <= g_idx;
            ptr         <= g_idx;
            grant       <= '0;
            state       <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (last_q) begin
              ptr       <= g_idx;
              grant     <= '0;
              msg_count <= msg_count + 1'b1;
              state     <= ST_IDLE;
            end else begin
              wd_cnt <= '0;
              state  <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_msg_arbiter.sv
// Directed bench for uart_tx_msg_arbiter: cycle table plus multi-cycle sequences.
module tb_uart_tx_msg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        tx_dv, tx_active, tx_done, busy, abort_pulse;
  logic [7:0]  tx_byte;
  logic [1:0]  abort_src;
  logic [15:0] msg_count;

  always #5 clk = ~clk;

  uart_tx_msg_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_dv        (tx_dv),
    .tx_byte      (tx_byte),
    .tx_active    (tx_active),
    .tx_done      (tx_done),
    .grant        (grant),
    .busy         (busy),
    .abort_pulse  (abort_pulse),
    .abort_src    (abort_src),
    .msg_count    (msg_count)
  );

  // Manual drive (table) versus automatic sources and UART model (sequences)
  logic       src_auto = 1'b0;
  logic [3:0] man_valid = '0;
  logic [7:0] man_data = '0;
  logic       man_last = 1'b0, man_act = 1'b0, man_done = 1'b0;

  logic [8:0]  sq [4][$];
  logic [3:0]  s_valid = '0, s_last = '0, hs_q = '0;
  logic [31:0] s_data = '0;
  logic        u_act = 1'b0, u_done = 1'b0;
  int          u_cnt = 0;
  logic [7:0]  log_b [$];
  logic [3:0]  log_g [$];

  assign req_valid = src_auto ? s_valid : man_valid;
  assign req_data  = src_auto ? s_data  : {24'h0, man_data};
  assign req_last  = src_auto ? s_last  : {3'b0, man_last};
  assign tx_active = src_auto ? u_act   : man_act;
  assign tx_done   = src_auto ? u_done  : man_done;

  always @(posedge clk) hs_q <= req_valid & req_ready;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (hs_q[i] && sq[i].size() > 0) void'(sq[i].pop_front());
      s_valid[i] = (sq[i].size() != 0);
      s_data[8*i +: 8] = 8'h00;
      s_last[i] = 1'b0;
      if (s_valid[i]) begin
        s_data[8*i +: 8] = sq[i][0][7:0];
        s_last[i] = sq[i][0][8];
      end
    end
  end

  always @(posedge clk) begin
    u_done <= 1'b0;
    if (tx_dv) begin
      u_act <= 1'b1;
      u_cnt <= 3;
    end else if (u_act) begin
      if (u_cnt == 0) begin
        u_act  <= 1'b0;
        u_done <= 1'b1;
      end else begin
        u_cnt <= u_cnt - 1;
      end
    end
  end

  always @(negedge clk) if (tx_dv) begin
    log_b.push_back(tx_byte);
    log_g.push_back(grant);
  end

  int n_vec = 0, n_bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic expire(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got no event expected event", name);
  endtask

  task automatic wait_log(input int n, input string name);
    int k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (log_b.size() < n && k < 300);
    if (log_b.size() < n) expire(name);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 300);
    if (busy) expire(name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) sq[i].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    log_b.delete();
    log_g.delete();
  endtask

  typedef struct {
    logic [3:0] valid; logic [7:0] data; logic last; logic act; logic done;
    logic [3:0] e_grant; logic [3:0] e_ready; logic e_dv; logic [7:0] e_byte;
    logic e_busy; logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // 3-byte message 41,42,43 then a 1-byte message held off by tx_active
    tbl[0]  = '{4'h0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0};
    tbl[1]  = '{4'h1, 8'h41, 0, 0, 0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0};
    tbl[2]  = '{4'h1, 8'h41, 0, 0, 0, 4'h1, 4'h1, 0, 8'h00, 1, 16'd0};
    tbl[3]  = '{4'h1, 8'h42, 0, 1, 0, 4'h1, 4'h0, 1, 8'h41, 1, 16'd0};
    tbl[4]  = '{4'h1, 8'h42, 0, 1, 0, 4'h1, 4'h0, 0, 8'h41, 1, 16'd0};
    tbl[5]  = '{4'h1, 8'h42, 0, 0, 1, 4'h1, 4'h0, 0, 8'h41, 1, 16'd0};
    tbl[6]  = '{4'h1, 8'h42, 0, 0, 0, 4'h1, 4'h1, 0, 8'h41, 1, 16'd0};
    tbl[7]  = '{4'h1, 8'h43, 1, 1, 0, 4'h1, 4'h0, 1, 8'h42, 1, 16'd0};
    tbl[8]  = '{4'h1, 8'h43, 1, 0, 1, 4'h1, 4'h0, 0, 8'h42, 1, 16'd0};
    tbl[9]  = '{4'h1, 8'h43, 1, 0, 0, 4'h1, 4'h1, 0, 8'h42, 1, 16'd0};
    tbl[10] = '{4'h0, 8'h00, 0, 1, 0, 4'h1, 4'h0, 1, 8'h43, 1, 16'd0};
    tbl[11] = '{4'h0, 8'h00, 0, 0, 1, 4'h1, 4'h0, 0, 8'h43, 1, 16'd0};
    tbl[12] = '{4'h0, 8'h00, 0, 0, 1, 4'h0, 4'h0, 0, 8'h43, 0, 16'd1};
    tbl[13] = '{4'h1, 8'h55, 1, 1, 0, 4'h0, 4'h0, 0, 8'h43, 0, 16'd1};
    tbl[14] = '{4'h1, 8'h55, 1, 1, 1, 4'h1, 4'h0, 0, 8'h43, 1, 16'd1};
    tbl[15] = '{4'h1, 8'h55, 1, 1, 0, 4'h1, 4'h0, 0, 8'h43, 1, 16'd1};
    tbl[16] = '{4'h1, 8'h55, 1, 0, 0, 4'h1, 4'h1, 0, 8'h43, 1, 16'd1};
    tbl[17] = '{4'h0, 8'h00, 0, 1, 0, 4'h1, 4'h0, 1, 8'h55, 1, 16'd1};
    tbl[18] = '{4'h0, 8'h00, 0, 0, 1, 4'h1, 4'h0, 0, 8'h55, 1, 16'd1};
    tbl[19] = '{4'h0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 0, 8'h55, 0, 16'd2};

    #3 rst = 1'b1;
    #2;
    chk("reset_state", {grant, req_ready, tx_dv, tx_byte, busy, abort_pulse, abort_src, msg_count}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      man_valid = tbl[i].valid;
      man_data  = tbl[i].data;
      man_last  = tbl[i].last;
      man_act   = tbl[i].act;
      man_done  = tbl[i].done;
      #1;
      chk($sformatf("vec%0d", i), {grant, req_ready, tx_dv, tx_byte, busy, msg_count},
          {tbl[i].e_grant, tbl[i].e_ready, tbl[i].e_dv, tbl[i].e_byte, tbl[i].e_busy, tbl[i].e_cnt});
    end

    // Two requesters together, req0 re-requests while req2 is being served
    src_auto = 1'b1;
    do_reset();
    sq[0].push_back({1'b0, 8'hA0}); sq[0].push_back({1'b1, 8'hA1});
    sq[2].push_back({1'b0, 8'hC0}); sq[2].push_back({1'b1, 8'hC1});
    wait_log(3, "t2_third_byte");
    sq[0].push_back({1'b1, 8'hB0});
    wait_log(5, "t2_all_bytes");
    begin
      logic [11:0] exp2 [5];
      exp2 = '{{4'h1, 8'hA0}, {4'h1, 8'hA1}, {4'h4, 8'hC0}, {4'h4, 8'hC1}, {4'h1, 8'hB0}};
      for (int i = 0; i < 5 && i < log_b.size(); i++)
        chk($sformatf("t2_byte%0d", i), {log_g[i], log_b[i]}, exp2[i]);
    end
    wait_idle("t2_idle");
    chk("t2_msg_count", msg_count, 16'd3);

    // All four requesters continuously valid with 1-byte messages
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) sq[i].push_back({1'b1, 4'(i), 4'(k)});
    wait_log(8, "t3_all_bytes");
    for (int i = 0; i < 8 && i < log_b.size(); i++)
      chk($sformatf("t3_grant%0d", i), {log_g[i], log_b[i]},
          {4'b0001 << (i % 4), 4'(i % 4), 4'(i / 4)});

    // Watchdog: req1 stalls after a non-last byte, req3 waits behind it
    do_reset();
    sq[1].push_back({1'b0, 8'h77});
    wait_log(1, "t4_first_byte");
    sq[3].push_back({1'b1, 8'h99});
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!tx_done && k < 50);
      if (!tx_done) expire("t4_tx_done");
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (!abort_pulse && k > 1) chk("t4_grant_held", grant, 4'h2);
      end while (!abort_pulse && k < 40);
      chk("t4_abort_latency", k, 17);
      chk("t4_abort_state", {abort_src, grant, busy, msg_count}, {2'd1, 4'h0, 1'b0, 16'd0});
      @(negedge clk);
      chk("t4_abort_one_shot", {abort_pulse, grant}, {1'b0, 4'h8});
    end
    wait_log(2, "t4_req3_byte");
    if (log_b.size() >= 2) chk("t4_req3_sent", {log_g[1], log_b[1]}, {4'h8, 8'h99});
    wait_idle("t4_idle");
    chk("t4_msg_count", msg_count, 16'd1);

    // Asynchronous reset in WAIT of byte 2 of 4, then a fresh message
    log_b.delete();
    log_g.delete();
    for (int i = 0; i < 4; i++) sq[0].push_back({i == 3, 8'hD0 + 8'(i)});
    wait_log(2, "t5_second_byte");
    rst = 1'b1;
    #1;
    chk("t5_async_reset", {grant, req_ready, tx_dv, tx_byte, busy, abort_pulse, abort_src, msg_count}, '0);
    do_reset();
    sq[0].push_back({1'b0, 8'hE0}); sq[0].push_back({1'b1, 8'hE1});
    sq[1].push_back({1'b1, 8'hF0});
    wait_log(3, "t5_fresh_bytes");
    if (log_b.size() >= 3) begin
      chk("t5_byte0", {log_g[0], log_b[0]}, {4'h1, 8'hE0});
      chk("t5_byte1", {log_g[1], log_b[1]}, {4'h1, 8'hE1});
      chk("t5_byte2", {log_g[2], log_b[2]}, {4'h2, 8'hF0});
    end
    wait_idle("t5_idle");
    chk("t5_msg_count", msg_count, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
